// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } arb_state_t;

    localparam int DEF_AW       = 32;
    localparam int DEF_DW       = 32;
    localparam int DEF_MAX_WAIT = 4;
    // Wide enough for the largest allowed MAX_WAIT (15).
    localparam int WAIT_W       = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and unified memory port seen by the arbiter.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Requesters hold *_req (and their payload) high until the one-cycle *_ack;
    // the arbiter holds mem_req and the mem_* payload stable until mem_ready.
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          core_stall;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        output if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
               core_stall
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
               core_stall
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and data
// accesses: data has priority, a saturating counter forces fetch after MAX_WAIT data grants.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus,
    output arb_state_t        state_dbg,
    output logic [WAIT_W-1:0] wait_cnt_dbg
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    arb_state_t        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [AW-1:0]     mem_addr_q;
    logic [DW-1:0]     mem_wdata_q;
    logic              if_ack_q;
    logic              dm_ack_q;
    logic [DW-1:0]     if_rdata_q;
    logic [DW-1:0]     dm_rdata_q;
    logic              grant_dm;
    logic              grant_if;

    // The ack cycle blocks arbitration: the requester still holds req while it sees ack.
    always_comb begin
        grant_dm = 1'b0;
        grant_if = 1'b0;
        if (state == IDLE && !if_ack_q && !dm_ack_q) begin
            grant_dm = bus.dm_req && (!bus.if_req || (wait_cnt < MAX_WAIT_C));
            grant_if = !grant_dm && bus.if_req;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        state       <= DM_BUSY;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.dm_we;
                        mem_addr_q  <= bus.dm_addr;
                        mem_wdata_q <= bus.dm_wdata;
                        if (bus.if_req && (wait_cnt < MAX_WAIT_C)) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else if (grant_if) begin
                        state      <= IF_BUSY;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= bus.if_addr;
                        wait_cnt   <= '0;
                    end
                end
                IF_BUSY: begin
                    if (bus.mem_ready) begin
                        state      <= IDLE;
                        mem_req_q  <= 1'b0;
                        if_ack_q   <= 1'b1;
                        if_rdata_q <= bus.mem_rdata;
                    end
                end
                DM_BUSY: begin
                    if (bus.mem_ready) begin
                        state     <= IDLE;
                        mem_req_q <= 1'b0;
                        dm_ack_q  <= 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_q <= bus.mem_rdata;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.if_ack     = if_ack_q;
    assign bus.dm_ack     = dm_ack_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.dm_rdata   = dm_rdata_q;
    // Stall releases in the ack cycle so the PC advances exactly once per access.
    assign bus.core_stall = (bus.if_req & ~if_ack_q) | (bus.dm_req & ~dm_ack_q);

    assign state_dbg    = state;
    assign wait_cnt_dbg = wait_cnt;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified, variable-latency memory port between the core's instruction-fetch port and its data-memory port.
- Data accesses have fixed priority over fetch. A starvation counter guarantees fetch progress.
- Requests are registered and replayed to memory under a ready handshake.
- Drives a stall signal that freezes the program counter and pipeline while either side is waiting.

Parameters:
- AW, 32, address width of all ports.
- DW, 32, data width of all ports.
- MAX_WAIT, 4, consecutive data grants allowed while fetch is pending before fetch is forced (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  AW  fetch address (PC).
- if_rdata  out  DW  fetched instruction; valid in the if_ack cycle and held afterwards.
- if_ack  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request; held high until dm_ack.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  AW  data address (ALU result).
- dm_wdata  in  DW  store data.
- dm_rdata  out  DW  load data; valid in the dm_ack cycle and held afterwards.
- dm_ack  out  1  one-cycle completion pulse for data.
- mem_req  out  1  request to memory, registered.
- mem_we  out  1  registered write enable.
- mem_addr  out  AW  registered address.
- mem_wdata  out  DW  registered write data.
- mem_rdata  in  DW  memory read data; valid with mem_ready.
- mem_ready  in  1  memory completes the current access this cycle.
- core_stall  out  1  combinational: (if_req & ~if_ack) | (dm_req & ~dm_ack).

Behaviour:
- Reset (rst=0, async):
  - State = IDLE, wait_cnt = 0.
  - mem_req, mem_we, if_ack, dm_ack = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
  - Reset mid-transaction aborts it: mem_req drops immediately and no ack is issued.
- FSM states: IDLE, IF_BUSY, DM_BUSY.
- IDLE arbitration, evaluated each cycle:
  - Grant data if dm_req & (~if_req | wait_cnt < MAX_WAIT).
  - Otherwise grant fetch if if_req.
  - Otherwise stay in IDLE.
- On a grant, the next edge:
  - Latches addr/we/wdata into the mem_* registers and sets mem_req=1.
  - Moves to DM_BUSY or IF_BUSY. A fetch always drives mem_we=0.
- wait_cnt:
  - On a data grant while if_req=1: wait_cnt increments, saturating at MAX_WAIT.
  - On a fetch grant: wait_cnt clears.
  - Otherwise wait_cnt holds.
- BUSY states:
  - mem_* stay stable until mem_ready=1.
  - On a mem_ready edge, mem_req goes to 0 and the state returns to IDLE.
  - The granted side's ack pulses for exactly one cycle.
  - if_rdata (fetch) or dm_rdata (data read) captures mem_rdata on that edge. A data write leaves dm_rdata unchanged.
- Latency: request sampled in IDLE at edge N → mem_req high after N. With mem_ready in the first BUSY cycle, ack is high after edge N+1. Minimum 2 cycles per access.
- After each completion, one IDLE cycle follows (no back-to-back grant).
- Boundary conditions:
  - mem_ready while in IDLE is ignored.
  - A requester that drops req during BUSY does not cancel the access; the access completes and the ack still pulses.
  - Address/data changes during BUSY are ignored (values were latched at grant).
  - Simultaneous if_req and dm_req with wait_cnt=MAX_WAIT: fetch wins.
  - if_ack and dm_ack are never high in the same cycle.
- core_stall drops in the ack cycle, so the PC advances exactly once per fetch.

Decomposition:
- Shared package holds:
  - The state enum {IDLE, IF_BUSY, DM_BUSY} as a 2-bit encoding.
  - The default AW/DW constants.
  - The MAX_WAIT default.
- Single module; no sub-module is natural. The FSM and saturating counter fit together in about 150–250 lines.

Test Plan:
- Fetch alone: if_req=1, if_addr=0x0000_0010; mem_ready after 3 BUSY cycles with mem_rdata=0x0000_0093 → mem_addr=0x10, mem_we=0; if_ack pulses once; if_rdata=0x93; core_stall high until the ack cycle.
- Data write: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF; ready after 1 cycle → mem_we=1, mem_wdata=0xDEADBEEF; dm_ack pulses; dm_rdata unchanged (0).
- Priority: if_req and dm_req both high from reset → data granted first; fetch granted after dm_ack plus one IDLE cycle.
- Starvation with MAX_WAIT=4: if_req held high, dm_req re-asserted continuously, ready in 1 cycle → exactly 4 data grants, then 1 fetch grant, then wait_cnt=0.
- Reset mid-access: rst low during DM_BUSY before mem_ready → mem_req=0 asynchronously; no dm_ack; after release the state is IDLE and the re-request completes normally.
- Requester withdraw: dm_req dropped in the second BUSY cycle; mem_ready in the third → mem_req held until ready, dm_ack still pulses, no new grant follows.
